// File: rtl/multi_channel_pulse_gen_if.sv
// Channel bundle for the pulse generator: raw inputs and enables in,
// one-cycle pulses, debounced levels and their OR out.
interface multi_channel_pulse_gen_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] signal;
  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] level;
  logic                any_pulse;

  modport master (
    output signal, enable,
    input  pulse, level, any_pulse
  );

  modport slave (
    input  signal, enable,
    output pulse, level, any_pulse
  );
endinterface

// File: rtl/multi_channel_pulse_gen.sv
// Per-channel synchroniser, debouncer, edge detector and optional auto-repeat
// producing single-cycle registered pulses from asynchronous inputs.
module multi_channel_pulse_gen #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input logic                      clock,
  input logic                      reset,
  multi_channel_pulse_gen_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W = ($clog2(RMAX + 1) > 0) ? $clog2(RMAX + 1) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RC_W-1:0] RP_LAST = RC_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  localparam bit REPEAT_ON = (REPEAT_DELAY > 0);
  localparam bit MODE_RISE = (EDGE_MODE == 0) || (EDGE_MODE == 2);
  localparam bit MODE_FALL = (EDGE_MODE == 1) || (EDGE_MODE == 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] pulse_q;
  logic                any_q;
  logic [DB_W-1:0]     deb_cnt [CHANNELS];
  logic [RC_W-1:0]     rep_cnt [CHANNELS];
  state_t              state   [CHANNELS];

  logic [CHANNELS-1:0] deb_done;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] rep_fire;
  logic [CHANNELS-1:0] pulse_next;

  // Events of the coming edge: debounced level change and repeat expiry.
  // A falling level cancels any repeat pulse scheduled on the same edge.
  always_comb begin
    deb_done   = '0;
    rise       = '0;
    fall       = '0;
    rep_fire   = '0;
    pulse_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      deb_done[i]   = (s2[i] != level_q[i]) && (deb_cnt[i] == DB_LAST);
      rise[i]       = deb_done[i] & s2[i];
      fall[i]       = deb_done[i] & ~s2[i];
      rep_fire[i]   = REPEAT_ON && !fall[i] &&
                      (((state[i] == HOLD)   && (rep_cnt[i] == RD_LAST)) ||
                       ((state[i] == REPEAT) && (rep_cnt[i] == RP_LAST)));
      pulse_next[i] = bus.enable[i] &
                      ((MODE_RISE & rise[i]) | (MODE_FALL & fall[i]) | rep_fire[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      level_q <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        deb_cnt[i] <= '0;
        rep_cnt[i] <= '0;
        state[i]   <= IDLE;
      end
    end else begin
      s1      <= bus.signal;
      s2      <= s1;
      pulse_q <= pulse_next;
      any_q   <= |pulse_next;
      for (int i = 0; i < CHANNELS; i++) begin
        if (s2[i] == level_q[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_done[i]) begin
          level_q[i] <= s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DB_W'(1);
        end

        if (REPEAT_ON) begin
          case (state[i])
            IDLE: begin
              if (rise[i]) begin
                state[i]   <= HOLD;
                rep_cnt[i] <= '0;
              end
            end
            HOLD: begin
              if (fall[i]) begin
                state[i]   <= IDLE;
                rep_cnt[i] <= '0;
              end else if (rep_cnt[i] == RD_LAST) begin
                state[i]   <= REPEAT;
                rep_cnt[i] <= '0;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + RC_W'(1);
              end
            end
            REPEAT: begin
              if (fall[i]) begin
                state[i]   <= IDLE;
                rep_cnt[i] <= '0;
              end else if (rep_cnt[i] == RP_LAST) begin
                rep_cnt[i] <= '0;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + RC_W'(1);
              end
            end
            default: begin
              state[i]   <= IDLE;
              rep_cnt[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.pulse     = pulse_q;
  assign bus.level     = level_q;
  assign bus.any_pulse = any_q;

endmodule

// File: tb/tb_multi_channel_pulse_gen.sv
// Directed bench: four generator instances (rising, both, falling, auto-repeat)
// with a scoreboard of expected pulse/level events keyed by clock edge.
module tb_multi_channel_pulse_gen;

  logic clock;
  logic reset;

  logic [3:0] sig [4];
  logic [3:0] en  [4];
  logic [3:0] pls [4];
  logic [3:0] lvl [4];
  logic       anyp [4];

  int emode [4] = '{0, 2, 1, 0};

  typedef struct {
    int cyc;
    int inst;
    int ch;
    bit is_level;
    bit val;
  } ev_t;

  ev_t        sb [$];
  logic [3:0] exp_level [4];
  int         cyc;
  int         vectors;
  int         miscompares;

  multi_channel_pulse_gen_if #(.CHANNELS(4)) bus0 ();
  multi_channel_pulse_gen_if #(.CHANNELS(4)) bus1 ();
  multi_channel_pulse_gen_if #(.CHANNELS(4)) bus2 ();
  multi_channel_pulse_gen_if #(.CHANNELS(4)) bus3 ();

  assign bus0.signal = sig[0];
  assign bus1.signal = sig[1];
  assign bus2.signal = sig[2];
  assign bus3.signal = sig[3];
  assign bus0.enable = en[0];
  assign bus1.enable = en[1];
  assign bus2.enable = en[2];
  assign bus3.enable = en[3];
  assign pls[0] = bus0.pulse;
  assign pls[1] = bus1.pulse;
  assign pls[2] = bus2.pulse;
  assign pls[3] = bus3.pulse;
  assign lvl[0] = bus0.level;
  assign lvl[1] = bus1.level;
  assign lvl[2] = bus2.level;
  assign lvl[3] = bus3.level;
  assign anyp[0] = bus0.any_pulse;
  assign anyp[1] = bus1.any_pulse;
  assign anyp[2] = bus2.any_pulse;
  assign anyp[3] = bus3.any_pulse;

  multi_channel_pulse_gen #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
                            .REPEAT_DELAY(0), .REPEAT_PERIOD(1))
    u_rise (.clock(clock), .reset(reset), .bus(bus0.slave));
  multi_channel_pulse_gen #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2),
                            .REPEAT_DELAY(0), .REPEAT_PERIOD(1))
    u_both (.clock(clock), .reset(reset), .bus(bus1.slave));
  multi_channel_pulse_gen #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1),
                            .REPEAT_DELAY(0), .REPEAT_PERIOD(1))
    u_fall (.clock(clock), .reset(reset), .bus(bus2.slave));
  multi_channel_pulse_gen #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
                            .REPEAT_DELAY(10), .REPEAT_PERIOD(5))
    u_rep (.clock(clock), .reset(reset), .bus(bus3.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input int inst, input logic [3:0] ep);
    vectors++;
    assert (pls[inst] === ep) else begin
      miscompares++;
      $error("FAIL pulse inst%0d cyc%0d: got %b expected %b", inst, cyc, pls[inst], ep);
    end
    vectors++;
    assert (lvl[inst] === exp_level[inst]) else begin
      miscompares++;
      $error("FAIL level inst%0d cyc%0d: got %b expected %b", inst, cyc, lvl[inst], exp_level[inst]);
    end
    vectors++;
    assert (anyp[inst] === (|ep)) else begin
      miscompares++;
      $error("FAIL any_pulse inst%0d cyc%0d: got %b expected %b", inst, cyc, anyp[inst], |ep);
    end
  endtask

  task automatic tick();
    logic [3:0] ep;
    @(posedge clock);
    #1;
    cyc++;
    for (int inst = 0; inst < 4; inst++) begin
      ep = 4'h0;
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].cyc == cyc && sb[k].inst == inst) begin
          if (sb[k].is_level) exp_level[inst][sb[k].ch] = sb[k].val;
          else ep[sb[k].ch] = 1'b1;
          sb.delete(k);
        end
      end
      check(inst, ep);
    end
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) tick();
  endtask

  // A raw change applied now is accepted on the sixth edge from here.
  task automatic expect_change(input int inst, input int ch, input bit val);
    bit hit;
    sb.push_back('{cyc + 6, inst, ch, 1'b1, val});
    hit = val ? (emode[inst] != 1) : (emode[inst] != 0);
    if (hit && en[inst][ch]) sb.push_back('{cyc + 6, inst, ch, 1'b0, 1'b1});
  endtask

  task automatic set_sig(input int inst, input int ch, input bit val);
    sig[inst][ch] = val;
    expect_change(inst, ch, val);
  endtask

  initial begin
    int c0;
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sig[i] = 4'h0;
      en[i] = 4'hF;
      exp_level[i] = 4'h0;
    end
    #1;
    for (int i = 0; i < 4; i++) check(i, 4'h0);
    ticks(2);
    reset = 1'b0;
    ticks(2);

    // clean press and release on channel 0
    set_sig(0, 0, 1'b1);
    ticks(8);
    set_sig(0, 0, 1'b0);
    ticks(8);

    // 3-cycle glitch is rejected, 6-cycle high is accepted
    sig[0][1] = 1'b1;
    ticks(3);
    sig[0][1] = 1'b0;
    ticks(8);
    set_sig(0, 1, 1'b1);
    ticks(6);
    set_sig(0, 1, 1'b0);
    ticks(8);

    // both-edge and falling-edge instances
    set_sig(1, 0, 1'b1);
    set_sig(2, 0, 1'b1);
    ticks(8);
    set_sig(1, 0, 1'b0);
    set_sig(2, 0, 1'b0);
    ticks(8);

    // auto-repeat: held 40 cycles, repeats at +16 then every 5
    c0 = cyc;
    set_sig(3, 2, 1'b1);
    for (int k = 0; k < 6; k++) sb.push_back('{c0 + 16 + 5 * k, 3, 2, 1'b0, 1'b1});
    ticks(40);
    set_sig(3, 2, 1'b0);
    ticks(14);

    // enable low during the press: level follows, no pulse, no catch-up
    en[0][3] = 1'b0;
    set_sig(0, 3, 1'b1);
    ticks(8);
    en[0][3] = 1'b1;
    ticks(4);
    set_sig(0, 3, 1'b0);
    ticks(8);

    // simultaneous presses on channels 0 and 1
    set_sig(0, 0, 1'b1);
    set_sig(0, 1, 1'b1);
    ticks(8);
    set_sig(0, 0, 1'b0);
    set_sig(0, 1, 1'b0);
    ticks(8);

    // reset while channel 0 debounce counter is at 2, channel 1 level high
    set_sig(0, 1, 1'b1);
    ticks(8);
    sig[0][0] = 1'b1;
    ticks(4);
    reset = 1'b1;
    #1;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      exp_level[i] = 4'h0;
      check(i, 4'h0);
    end
    ticks(2);
    reset = 1'b0;
    expect_change(0, 0, 1'b1);
    expect_change(0, 1, 1'b1);
    ticks(8);
    set_sig(0, 0, 1'b0);
    set_sig(0, 1, 1'b0);
    ticks(8);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_channel_pulse_gen.md
Name: multi_channel_pulse_gen

Overview:
- Parametrised, fully synchronous single-pulse generator for CHANNELS asynchronous inputs (push-buttons, switches, step-clock requests for the multicycle CPU).
- Per channel: synchronises, debounces and edge-detects the input, then emits exactly one clock-wide pulse per qualified edge.
- Optional auto-repeat emits further pulses while an input is held.
- Outputs are plain registers with no clock gating, so they can drive CPU-side enables directly.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change (>=1).
- EDGE_MODE, 0, 0 = pulse on rising stable edge, 1 = falling, 2 = both.
- REPEAT_DELAY, 0, cycles of continuous stable-high before the first repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 1, cycles between successive repeat pulses (>=1; ignored when REPEAT_DELAY = 0).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- signal  input  CHANNELS  raw asynchronous inputs, active-high.
- enable  input  CHANNELS  per-channel pulse enable (synchronous).
- pulse  output  CHANNELS  one-cycle pulses, registered.
- level  output  CHANNELS  debounced stable level, registered.
- any_pulse  output  1  registered OR of the pulse vector computed in the same cycle, i.e. aligned with pulse.

Behaviour:
- Reset: sync FFs, stable level, debounce counters, repeat counters and state all go to 0. pulse = 0, level = 0, any_pulse = 0, state = IDLE.
- An input held high through reset release produces a normal rising pulse once debounced.
- Reset asserted mid-operation aborts any debounce or repeat in progress immediately. No pulse is emitted during reset.
- Synchroniser: two FFs per channel (s1, s2).
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES) with a minimum of 1:
  - If s2 == level, the counter is cleared to 0.
  - Else if counter == DEBOUNCE_CYCLES-1, then level <= s2 and the counter is cleared.
  - Else the counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES never changes level.
- Latency: a raw change set up before edge 0 updates level at edge 1+DEBOUNCE_CYCLES. The pulse is asserted in that same cycle: level and pulse update on the same edge.
- Edge pulse: on the edge where level changes, pulse[i] <= enable[i] & (edge matches EDGE_MODE). Otherwise pulse[i] <= 0 unless a repeat pulse fires.
- Pulse width is exactly 1 clock. No two consecutive pulse cycles occur when REPEAT_PERIOD > 1. With REPEAT_PERIOD = 1, repeat pulses are back-to-back every cycle.
- Repeat FSM per channel (only when REPEAT_DELAY > 0):
  - IDLE: on a level 0->1 transition, go to HOLD and load cnt = 0.
  - HOLD: cnt increments each cycle while level = 1. When cnt == REPEAT_DELAY-1, emit a repeat pulse, go to REPEAT and set cnt = 0.
  - REPEAT: cnt increments. When cnt == REPEAT_PERIOD-1, emit a pulse and clear cnt.
  - From HOLD or REPEAT, a level 1->0 transition returns to IDLE the same edge and no repeat pulse is emitted that cycle. A falling-edge pulse (EDGE_MODE 1/2) is still emitted on that edge.
- Repeat pulses fire in any EDGE_MODE and are gated by enable.
- enable = 0: pulse is forced to 0, but debounce, level and the FSM keep running. Re-enabling never produces a catch-up pulse. A repeat in progress resumes pulsing on its normal schedule.
- Channels are fully independent. Simultaneous edges on several channels give simultaneous pulses, and any_pulse is 1 for that one cycle.
- Counter width for repeat: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).

Test Plan:
- Bench parameters: CHANNELS=4, DEBOUNCE_CYCLES=4, EDGE_MODE=0, REPEAT_DELAY=0, enable=4'hF.
- Clean press: signal[0] 0->1 before edge 0 -> level[0] and pulse[0] = 1 after edge 5 for exactly one cycle, any_pulse = 1 the same cycle; release gives no pulse.
- Glitch rejection: signal[1] high for 3 cycles then low -> level[1] stays 0 and pulse stays 4'h0. A 6-cycle high instead gives exactly one pulse[1].
- Modes: EDGE_MODE=2 with a press then release -> two pulses, one after each debounced edge. EDGE_MODE=1 -> a pulse on release only.
- Auto-repeat: REPEAT_DELAY=10, REPEAT_PERIOD=5, signal[2] held high 40 cycles.
  - Required pulses (edge numbers): 5 (edge), 15, 20, 25, 30, 35, 40, continuing every 5 cycles while held.
  - After release: no further pulses; state returns to IDLE once level[2] = 0.
- Enable and simultaneity:
  - enable[3] = 0 during a press -> no pulse[3] but level[3] = 1. Raising enable afterwards produces no pulse.
  - Pressing channels 0 and 1 on the same edge -> pulse = 4'h3 for one cycle.
- Reset mid-debounce: assert reset while the ch0 counter = 2 -> all outputs 0 immediately. After release with the input still high, pulse[0] fires 5 cycles later.
